// File: rtl/uid_pkg.sv
// Shared definitions for the UID test memory writer and the UID test controller.
// The CSUM state exists only when UID_WR_CHECKSUM_EN is defined.
package uid_pkg;

   localparam int UID_WORDS       = 6;
   localparam int UID_ADDR_W      = 3;
   localparam int UID_WAIT_CYCLES = 2;
   localparam int UID_BYTE_W      = 8;
   localparam int UID_WORD_W      = 16;
   localparam int UID_CSUM_W      = 16;
   localparam int UID_CNT_W       = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_WRITE,
      ST_WAIT,
      ST_DONE
`ifdef UID_WR_CHECKSUM_EN
      ,
      ST_CSUM
`endif
   } uid_state_e;

   // Little-endian pairing: first byte of the pair lands in bits [7:0].
   function automatic logic [UID_WORD_W-1:0] uid_pack(input logic [UID_BYTE_W-1:0] lo,
                                                      input logic [UID_BYTE_W-1:0] hi);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/uid_byte_packer.sv
// Byte-pair capture for the UID writer: accepts bytes while enabled and emits a
// one-cycle word_valid with the packed 16-bit word after the high byte lands.
module uid_byte_packer
   import uid_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  sel_high,
   input  logic                  in_valid,
   input  logic [UID_BYTE_W-1:0] in_data,
   output logic                  in_ready,
   output logic                  accept,
   output logic                  word_valid,
   output logic [UID_WORD_W-1:0] word
);

   logic [UID_BYTE_W-1:0] lo_q;
   logic [UID_BYTE_W-1:0] hi_q;
   logic                  vld_q;

   assign in_ready   = en;
   assign accept     = en & in_valid;
   assign word_valid = vld_q;
   assign word       = uid_pack(lo_q, hi_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         lo_q  <= '0;
         hi_q  <= '0;
         vld_q <= 1'b0;
      end else begin
         vld_q <= accept & sel_high;
         if (accept && !sel_high) lo_q <= in_data;
         if (accept && sel_high)  hi_q <= in_data;
      end
   end

endmodule

// File: rtl/uid_test_writer.sv
// Streams byte pairs into the UID test memory at addresses 0..WORDS-1 with settle gaps.
// Optional UID_WR_CHECKSUM_EN appends an XOR checksum word at address WORDS.
module uid_test_writer
   import uid_pkg::*;
#(
   parameter int ADDR_W      = UID_ADDR_W,
   parameter int WORDS       = UID_WORDS,
   parameter int WAIT_CYCLES = UID_WAIT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [UID_BYTE_W-1:0] in_data,
   output logic                  in_ready,
   output logic                  wren,
   output logic [ADDR_W-1:0]     address,
   output logic [UID_WORD_W-1:0] data,
   output logic                  busy,
   output logic                  done
);

   localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(WORDS - 1);
   localparam logic [UID_CNT_W-1:0] WAIT_INIT = UID_CNT_W'(WAIT_CYCLES);

   uid_state_e state_q, state_d;

   logic [ADDR_W-1:0]     addr_q;
   logic [UID_CNT_W-1:0]  cnt_q;
   logic                  addr_clr;
   logic                  addr_inc;
   logic                  cnt_load;
   logic                  pk_en;
   logic                  pk_high;
   logic                  pk_accept;
   logic                  pk_word_valid;
   logic [UID_WORD_W-1:0] pk_word;

`ifdef UID_WR_CHECKSUM_EN
   localparam logic [ADDR_W-1:0] CSUM_ADDR = ADDR_W'(WORDS);

   logic                  csum_go;
   logic                  csum_sel_q;
   logic [UID_CSUM_W-1:0] csum_q;
`endif

   uid_byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .en         (pk_en),
      .sel_high   (pk_high),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .accept     (pk_accept),
      .word_valid (pk_word_valid),
      .word       (pk_word)
   );

   always_comb begin
      state_d  = state_q;
      addr_clr = 1'b0;
      addr_inc = 1'b0;
      cnt_load = 1'b0;
      pk_en    = 1'b0;
      pk_high  = 1'b0;
`ifdef UID_WR_CHECKSUM_EN
      csum_go  = 1'b0;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               addr_clr = 1'b1;
               state_d  = ST_LOW;
            end
         end
         ST_LOW: begin
            pk_en = 1'b1;
            if (pk_accept) state_d = ST_HIGH;
         end
         ST_HIGH: begin
            pk_en   = 1'b1;
            pk_high = 1'b1;
            if (pk_accept) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            cnt_load = 1'b1;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            // Leaving on the last count keeps the settle gap at exactly WAIT_CYCLES.
            if (cnt_q <= UID_CNT_W'(1)) begin
`ifdef UID_WR_CHECKSUM_EN
               if (addr_q == LAST_ADDR) begin
                  csum_go = 1'b1;
                  state_d = ST_CSUM;
               end else if (addr_q == CSUM_ADDR) begin
                  state_d = ST_DONE;
               end else begin
                  addr_inc = 1'b1;
                  state_d  = ST_LOW;
               end
`else
               if (addr_q == LAST_ADDR) begin
                  state_d = ST_DONE;
               end else begin
                  addr_inc = 1'b1;
                  state_d  = ST_LOW;
               end
`endif
            end
         end
`ifdef UID_WR_CHECKSUM_EN
         ST_CSUM: begin
            cnt_load = 1'b1;
            state_d  = ST_WAIT;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (addr_clr)      addr_q <= '0;
         else if (addr_inc) addr_q <= addr_q + 1'b1;
`ifdef UID_WR_CHECKSUM_EN
         else if (csum_go)  addr_q <= CSUM_ADDR;
`endif
         if (cnt_load)                          cnt_q <= WAIT_INIT;
         else if (state_q == ST_WAIT && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      end
   end

`ifdef UID_WR_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q     <= '0;
         csum_sel_q <= 1'b0;
      end else if (addr_clr) begin
         csum_q     <= '0;
         csum_sel_q <= 1'b0;
      end else begin
         if (pk_word_valid) csum_q <= csum_q ^ pk_word;
         if (csum_go)       csum_sel_q <= 1'b1;
      end
   end

   assign wren = pk_word_valid | (state_q == ST_CSUM);
   assign data = csum_sel_q ? csum_q : pk_word;
`else
   assign wren = pk_word_valid;
   assign data = pk_word;
`endif

   assign address = addr_q;
   assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_uid_test_writer.sv
// Directed and randomized loads of uid_test_writer checked against a word-list model.
module tb_uid_test_writer;
   import uid_pkg::*;

   localparam int ADDR_W      = UID_ADDR_W;
   localparam int WORDS       = UID_WORDS;
   localparam int WAIT_CYCLES = UID_WAIT_CYCLES;
   localparam int NB          = 2 * WORDS;
`ifdef UID_WR_CHECKSUM_EN
   localparam int NWR  = WORDS + 1;
   localparam int LAT0 = 1 + WORDS * (3 + WAIT_CYCLES) + 1 + WAIT_CYCLES;
`else
   localparam int NWR  = WORDS;
   localparam int LAT0 = 1 + WORDS * (3 + WAIT_CYCLES);
`endif

   logic              clk;
   logic              rst;
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              wren;
   logic [ADDR_W-1:0] address;
   logic [15:0]       data;
   logic              busy;
   logic              done;

   uid_test_writer #(.ADDR_W(ADDR_W), .WORDS(WORDS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wren     (wren),
      .address  (address),
      .data     (data),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0]        bytes_m [NB];
   logic [ADDR_W-1:0] wa_q [$];
   logic [15:0]       wd_q [$];

   always @(negedge clk) begin
      if (wren) begin
         wa_q.push_back(address);
         wd_q.push_back(data);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_address"},  32'(address),  32'd0);
      chk({tag, "_data"},     32'(data),     32'd0);
      chk({tag, "_wren"},     32'(wren),     32'd0);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_busy"},     32'(busy),     32'd0);
      chk({tag, "_done"},     32'(done),     32'd0);
   endtask

   // gap_max: random stall cycles per byte while the writer is ready;
   // stall_byte: index of a byte that is withheld for 4 ready cycles;
   // abort_addr: raise rst in the WAIT after this address is written.
   task automatic run_load(input bit directed, input int gap_max, input int stall_byte,
                           input int abort_addr, input bit mid_start);
      int          idx      = 0;
      int          gap_left = 0;
      int          gap_sum  = 0;
      int          edges;
      bit          acc;
      bit          pulsed   = 1'b0;
      bit          fin      = 1'b0;
      logic [15:0] exp_word;
      logic [15:0] csum     = 16'h0;

      wa_q.delete();
      wd_q.delete();
      for (int i = 0; i < NB; i++)
         bytes_m[i] = directed ? 8'(8'h11 + i) : 8'($urandom);
      gap_left = $urandom_range(gap_max, 0);

      start    = 1'b1;
      in_valid = 1'b0;
      step();
      start = 1'b0;
      edges = 1;
      chk("start_done_clear", 32'(done),    32'd0);
      chk("start_busy",       32'(busy),    32'd1);
      chk("start_address",    32'(address), 32'd0);

      while (!fin && edges < 1000) begin
         if (in_ready && idx < NB && gap_left > 0) begin
            in_valid = 1'b0;
            in_data  = 8'hA5;
            gap_left--;
            gap_sum++;
            chk("stall_no_wren", 32'(wren), 32'd0);
         end else begin
            in_valid = 1'b1;
            in_data  = (idx < NB) ? bytes_m[idx] : 8'hEE;
         end
         if (in_ready && (idx % 2 == 1))
            chk("hold_low_byte", 32'(data[7:0]), 32'(bytes_m[idx-1]));
         if (mid_start && !pulsed && in_ready && address == ADDR_W'(1)) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end
         acc = in_valid && in_ready;
         step();
         start = 1'b0;
         edges++;
         if (acc) begin
            idx++;
            gap_left = (idx == stall_byte) ? 4 : int'($urandom_range(gap_max, 0));
         end
         if (wren) chk("wren_not_ready", 32'(in_ready), 32'd0);
         if (wren && 32'(address) == abort_addr) begin
            step();
            rst = 1'b1;
            step();
            rst      = 1'b0;
            in_valid = 1'b0;
            check_reset_outputs("abort");
            return;
         end
         fin = done;
      end

      if (!fin) chk("done_timeout", 32'(done), 32'd1);
      chk("done_latency", 32'(edges),       32'(LAT0 + gap_sum));
      chk("write_count",  32'(wa_q.size()), 32'(NWR));
      for (int w = 0; w < WORDS; w++) begin
         exp_word = {bytes_m[2*w+1], bytes_m[2*w]};
         csum     = csum ^ exp_word;
         if (w < wa_q.size()) begin
            chk("write_addr", 32'(wa_q[w]), 32'(w));
            chk("write_data", 32'(wd_q[w]), 32'(exp_word));
         end
      end
`ifdef UID_WR_CHECKSUM_EN
      if (wa_q.size() > WORDS) begin
         chk("csum_addr", 32'(wa_q[WORDS]), 32'(WORDS));
         chk("csum_data", 32'(wd_q[WORDS]), 32'(csum));
      end
`endif
      chk("done_busy",      32'(busy),    32'd0);
      chk("done_hold_addr", 32'(address), 32'(NWR - 1));
      step();
      chk("done_held",      32'(done),    32'd1);
      chk("done_no_ready",  32'(in_ready), 32'd0);
      in_valid = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h5A;
      repeat (3) step();
      check_reset_outputs("reset");
      rst      = 1'b0;
      in_valid = 1'b0;
      step();
      check_reset_outputs("idle");

      // Directed stream 0x11..0x1C with in_valid always high.
      run_load(1'b1, 0, -1, -1, 1'b0);
      // Same stream with the high byte of word 2 withheld; restart from DONE.
      run_load(1'b1, 0, 5, -1, 1'b0);
      // Abort during the settle after word 3, then a fresh load from address 0.
      run_load(1'b0, 0, -1, 3, 1'b0);
      run_load(1'b0, 2, -1, -1, 1'b0);
      // start pulsed while busy on word 1 must be ignored.
      run_load(1'b0, 1, -1, -1, 1'b1);
      // Randomized bytes and stalls.
      repeat (4) run_load(1'b0, 3, -1, -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
